// File: rtl/decodificador_display.sv
`default_nettype none
// ============================================================================
//  Module   : decodificador_display
//  Purpose  : Selectable hex-to-seven-segment decoder for an 8-digit display.
//             BTN picks one of four switch nibbles (SW0..SW3). That nibble is
//             decoded to an active-low hex glyph on SEG. The matching digit
//             anode (AN[BTN]) is driven low. Both outputs are registered.
//             There is no digit scanning: one digit is lit at a time.
//  Ports    : clk        system clock, rising edge
//             rst        asynchronous active-high reset (blanks outputs)
//             SW0..SW3   4-bit switch groups
//             BTN        2-bit group/digit select
//             AN[7:0]    digit anodes, active-low (AN[7:4] always 1)
//             SEG[6:0]   segments, active-low, SEG[0]=a .. SEG[6]=g
//  Config   : `DECOD_SYNC_EN defined   -> two-flop synchronizer on all
//                                         18 input bits, latency 3 cycles
//             `DECOD_SYNC_EN undefined -> inputs sampled directly,
//                                         latency 1 cycle
//  Revision : 1.0  initial release
// ============================================================================
module decodificador_display (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] SW0,
   input  logic [3:0] SW1,
   input  logic [3:0] SW2,
   input  logic [3:0] SW3,
   input  logic [1:0] BTN,
   output logic [7:0] AN,
   output logic [6:0] SEG
);

   localparam logic [6:0] c_seg_blank = 7'h7F;
   localparam logic [7:0] c_an_off    = 8'hFF;

   // All inputs travel as one bundle, so BTN and the switches always stay
   // aligned. SEG and AN therefore always come from the same sample.
   logic [17:0] w_raw;
   logic [17:0] w_in;

   assign w_raw = {BTN, SW3, SW2, SW1, SW0};

`ifdef DECOD_SYNC_EN
   logic [17:0] r_sync1;
   logic [17:0] r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = w_raw;
`endif

   logic [1:0] w_btn;
   logic [3:0] w_nib;
   logic [6:0] w_seg;
   logic [7:0] w_an;

   assign w_btn = w_in[17:16];

   // Select stage
   always_comb begin
      w_nib = w_in[3:0];
      case (w_btn)
         2'b00:   w_nib = w_in[3:0];
         2'b01:   w_nib = w_in[7:4];
         2'b10:   w_nib = w_in[11:8];
         default: w_nib = w_in[15:12];
      endcase
   end

   // Decode stage, active-low glyphs listed as {g,f,e,d,c,b,a}
   always_comb begin
      w_seg = c_seg_blank;
      case (w_nib)
         4'h0:    w_seg = 7'h40;
         4'h1:    w_seg = 7'h79;
         4'h2:    w_seg = 7'h24;
         4'h3:    w_seg = 7'h30;
         4'h4:    w_seg = 7'h19;
         4'h5:    w_seg = 7'h12;
         4'h6:    w_seg = 7'h02;
         4'h7:    w_seg = 7'h78;
         4'h8:    w_seg = 7'h00;
         4'h9:    w_seg = 7'h10;
         4'hA:    w_seg = 7'h08;
         4'hB:    w_seg = 7'h03;
         4'hC:    w_seg = 7'h46;
         4'hD:    w_seg = 7'h21;
         4'hE:    w_seg = 7'h06;
         default: w_seg = 7'h0E;
      endcase
   end

   // Anode stage: only digits 0..3 are ever addressed
   always_comb begin
      w_an = c_an_off;
      case (w_btn)
         2'b00:   w_an = 8'hFE;
         2'b01:   w_an = 8'hFD;
         2'b10:   w_an = 8'hFB;
         default: w_an = 8'hF7;
      endcase
   end

   // Output register: keeps the pins glitch-free, with no comb path to them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SEG <= c_seg_blank;
         AN  <= c_an_off;
      end else begin
         SEG <= w_seg;
         AN  <= w_an;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decodificador_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decodificador_display
//  Purpose  : Directed self-checking bench for decodificador_display.
//             It adapts its latency to the `DECOD_SYNC_EN build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decodificador_display;

`ifdef DECOD_SYNC_EN
   localparam int c_lat = 3;
`else
   localparam int c_lat = 1;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] SW0, SW1, SW2, SW3;
   logic [1:0] BTN;
   logic [7:0] AN;
   logic [6:0] SEG;

   int total = 0;
   int bad   = 0;

   decodificador_display dut (
      .clk (clk),
      .rst (rst),
      .SW0 (SW0),
      .SW1 (SW1),
      .SW2 (SW2),
      .SW3 (SW3),
      .BTN (BTN),
      .AN  (AN),
      .SEG (SEG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-written glyph table, taken from the datasheet order
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   // Inputs are driven at the negedge, and the bench waits out the
   // latency before it samples at a later negedge.
   task automatic wait_lat();
      repeat (c_lat) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      BTN = 2'b10; SW0 = 4'h0; SW1 = 4'h0; SW2 = 4'h3; SW3 = 4'h0;
      #1;
      total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL rst_init_seg got=%h exp=7f", SEG); end
      total++; if (AN !== 8'hFF)  begin bad++; $display("FAIL rst_init_an got=%h exp=ff", AN); end
      @(negedge clk); rst = 1'b0;
      wait_lat();
      total++; if (SEG !== 7'h30) begin bad++; $display("FAIL run_seg got=%h exp=30", SEG); end
      // Assert reset away from a clock edge: outputs must blank at once
      #2 rst = 1'b1;
      #1;
      total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL rst_async_seg got=%h exp=7f", SEG); end
      total++; if (AN !== 8'hFF)  begin bad++; $display("FAIL rst_async_an got=%h exp=ff", AN); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (SEG !== 7'h7F) begin bad++; $display("FAIL rst_hold_seg got=%h exp=7f", SEG); end
      rst = 1'b0;
      wait_lat();
      total++; if (SEG !== 7'h30) begin bad++; $display("FAIL rst_rel_seg got=%h exp=30", SEG); end
      total++; if (AN !== 8'hFB)  begin bad++; $display("FAIL rst_rel_an got=%h exp=fb", AN); end
   endtask

   task automatic test_group0();
      BTN = 2'b00; SW0 = 4'hA;
      wait_lat();
      total++; if (SEG !== 7'h08) begin bad++; $display("FAIL g0_a_seg got=%h exp=08", SEG); end
      total++; if (AN !== 8'hFE)  begin bad++; $display("FAIL g0_a_an got=%h exp=fe", AN); end
      SW0 = 4'h8;
      wait_lat();
      total++; if (SEG !== 7'h00) begin bad++; $display("FAIL g0_8_seg got=%h exp=00", SEG); end
      total++; if (AN !== 8'hFE)  begin bad++; $display("FAIL g0_8_an got=%h exp=fe", AN); end
   endtask

   task automatic test_group1();
      logic [3:0] vals [2];
      logic [6:0] exp_s [2];
      vals  = '{4'h5, 4'h1};
      exp_s = '{7'h12, 7'h79};
      BTN = 2'b01;
      for (int k = 0; k < 2; k++) begin
         SW1 = vals[k];
         // The unselected groups toggle on every cycle and must not matter
         for (int c = 0; c < c_lat + 3; c++) begin
            SW0 = 4'($urandom); SW2 = 4'($urandom); SW3 = 4'($urandom);
            @(posedge clk); @(negedge clk);
            if (c >= c_lat - 1) begin
               total++; if (SEG !== exp_s[k]) begin bad++; $display("FAIL g1_seg k=%0d c=%0d got=%h exp=%h", k, c, SEG, exp_s[k]); end
               total++; if (AN !== 8'hFD)     begin bad++; $display("FAIL g1_an k=%0d c=%0d got=%h exp=fd", k, c, AN); end
            end
         end
      end
   endtask

   task automatic test_group23();
      BTN = 2'b10; SW2 = 4'h9;
      wait_lat();
      total++; if (SEG !== 7'h10) begin bad++; $display("FAIL g2_seg got=%h exp=10", SEG); end
      total++; if (AN !== 8'hFB)  begin bad++; $display("FAIL g2_an got=%h exp=fb", AN); end
      BTN = 2'b11; SW3 = 4'h0;
      wait_lat();
      total++; if (SEG !== 7'h40) begin bad++; $display("FAIL g3_0_seg got=%h exp=40", SEG); end
      total++; if (AN !== 8'hF7)  begin bad++; $display("FAIL g3_0_an got=%h exp=f7", AN); end
      SW3 = 4'hB;
      wait_lat();
      total++; if (SEG !== 7'h03) begin bad++; $display("FAIL g3_b_seg got=%h exp=03", SEG); end
      total++; if (AN !== 8'hF7)  begin bad++; $display("FAIL g3_b_an got=%h exp=f7", AN); end
   endtask

   task automatic test_exhaustive();
      logic [7:0] exp_an [4];
      exp_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      for (int b = 0; b < 4; b++) begin
         for (int v = 0; v < 16; v++) begin
            SW0 = 4'($urandom); SW1 = 4'($urandom);
            SW2 = 4'($urandom); SW3 = 4'($urandom);
            BTN = 2'(b);
            case (b)
               0: SW0 = 4'(v);
               1: SW1 = 4'(v);
               2: SW2 = 4'(v);
               default: SW3 = 4'(v);
            endcase
            wait_lat();
            total++; if (SEG !== glyph(4'(v))) begin bad++; $display("FAIL ex_seg b=%0d v=%h got=%h exp=%h", b, v, SEG, glyph(4'(v))); end
            total++; if (AN !== exp_an[b])     begin bad++; $display("FAIL ex_an b=%0d v=%h got=%h exp=%h", b, v, AN, exp_an[b]); end
         end
      end
   endtask

   task automatic test_simultaneous();
      BTN = 2'b00; SW0 = 4'h4; SW3 = 4'h4;
      wait_lat();
      total++; if (SEG !== 7'h19 || AN !== 8'hFE) begin bad++; $display("FAIL sim_pre got=%h/%h exp=19/fe", SEG, AN); end
      BTN = 2'b11; SW3 = 4'hE;
      // Before the latency expires the old pair must hold, never a mix
      for (int c = 0; c < c_lat - 1; c++) begin
         @(posedge clk); @(negedge clk);
         total++; if (SEG !== 7'h19 || AN !== 8'hFE) begin bad++; $display("FAIL sim_hold c=%0d got=%h/%h exp=19/fe", c, SEG, AN); end
      end
      @(posedge clk); @(negedge clk);
      total++; if (SEG !== 7'h06) begin bad++; $display("FAIL sim_seg got=%h exp=06", SEG); end
      total++; if (AN !== 8'hF7)  begin bad++; $display("FAIL sim_an got=%h exp=f7", AN); end
   endtask

   initial begin
      rst = 1'b1;
      BTN = 2'b00; SW0 = 4'h0; SW1 = 4'h0; SW2 = 4'h0; SW3 = 4'h0;
      test_reset();
      test_group0();
      test_group1();
      test_group23();
      test_exhaustive();
      test_simultaneous();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
